// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin into one registered
// writeback port. Flush discards everything in flight; stale-epoch results are dropped at entry.
module wb_arbiter #(
  parameter int N_FU      = 4,
  parameter int DEPTH     = 2,
  parameter int PHYS_REGS = 64,
  parameter int PHYS_W    = $clog2(PHYS_REGS),
  parameter int DW        = 32,
  parameter int EPW       = 2,
  localparam int GID_W    = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_FU-1:0]               fu_valid,
  output logic [N_FU-1:0]               fu_ready,
  input  logic [N_FU-1:0][PHYS_W-1:0]   fu_pd,
  input  logic [N_FU-1:0][DW-1:0]       fu_data,
  input  logic [N_FU-1:0][EPW-1:0]      fu_epoch,
  input  logic                          flush_valid,
  input  logic [EPW-1:0]                flush_epoch,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [PHYS_W-1:0]             wb_pd,
  output logic [DW-1:0]                 wb_data,
  output logic [EPW-1:0]                wb_epoch,
  output logic [GID_W-1:0]              wb_grant_id,
  output logic [15:0]                   stale_drop_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(N_FU + 1);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [DCW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [PHYS_W-1:0] mem_pd   [N_FU][DEPTH];
  logic [DW-1:0]     mem_data [N_FU][DEPTH];
  logic [EPW-1:0]    mem_ep   [N_FU][DEPTH];

  logic [N_FU-1:0][AW-1:0] rd_ptr, wr_ptr;
  logic [N_FU-1:0][CW-1:0] cnt;
  logic [EPW-1:0]          cur_epoch, eff_epoch;
  logic [GID_W-1:0]        rr_ptr, winner, rr_next;
  logic [N_FU-1:0]         nonempty, enq, drop, deq;
  logic [DCW-1:0]          drop_n;
  logic                    found, load;
  logic [15:0]             drop_cnt;

  logic                    vld_p1;
  logic [PHYS_W-1:0]       pd_p1;
  logic [DW-1:0]           data_p1;
  logic [EPW-1:0]          epoch_p1;
  logic [GID_W-1:0]        gid_p1;

  // p0: entry handshake, epoch filter and arbitration
  always_comb begin
    eff_epoch = flush_valid ? flush_epoch : cur_epoch;
    fu_ready  = '0;
    nonempty  = '0;
    enq       = '0;
    drop      = '0;
    drop_n    = '0;
    for (int i = 0; i < N_FU; i++) begin
      fu_ready[i] = cnt[i] < CW'(DEPTH);
      nonempty[i] = cnt[i] != '0;
      enq[i]      = fu_valid[i] && fu_ready[i] && (fu_epoch[i] == eff_epoch);
      drop[i]     = fu_valid[i] && fu_ready[i] && (fu_epoch[i] != eff_epoch);
      drop_n      = drop_n + DCW'(drop[i]);
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_FU; k++) begin
      if (!found && nonempty[(int'(rr_ptr) + k) % N_FU]) begin
        found  = 1'b1;
        winner = GID_W'((int'(rr_ptr) + k) % N_FU);
      end
    end
    rr_next = GID_W'((int'(winner) + 1) % N_FU);
    load    = !flush_valid && (!vld_p1 || wb_ready) && found;
    deq     = '0;
    for (int i = 0; i < N_FU; i++) begin
      deq[i] = load && (winner == GID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      cur_epoch <= '0;
      rr_ptr    <= '0;
      drop_cnt  <= '0;
    end else begin
      drop_cnt <= sat_add16(drop_cnt, drop_n);
      if (flush_valid) begin
        // a same-cycle matching result lands in slot 0 of the emptied FIFO
        cur_epoch <= flush_epoch;
        for (int i = 0; i < N_FU; i++) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= AW'(enq[i]);
          cnt[i]    <= CW'(enq[i]);
        end
      end else begin
        if (load) rr_ptr <= rr_next;
        for (int i = 0; i < N_FU; i++) begin
          if (enq[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (deq[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
          cnt[i] <= cnt[i] + CW'(enq[i]) - CW'(deq[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FU; i++) begin
      if (enq[i]) begin
        mem_pd[i][flush_valid ? '0 : wr_ptr[i]]   <= fu_pd[i];
        mem_data[i][flush_valid ? '0 : wr_ptr[i]] <= fu_data[i];
        mem_ep[i][flush_valid ? '0 : wr_ptr[i]]   <= fu_epoch[i];
      end
    end
  end

  // p1: registered writeback output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      pd_p1    <= '0;
      data_p1  <= '0;
      epoch_p1 <= '0;
      gid_p1   <= '0;
    end else if (flush_valid) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      pd_p1    <= mem_pd[winner][rd_ptr[winner]];
      data_p1  <= mem_data[winner][rd_ptr[winner]];
      epoch_p1 <= mem_ep[winner][rd_ptr[winner]];
      gid_p1   <= winner;
    end else if (wb_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign wb_valid       = vld_p1;
  assign wb_pd          = pd_p1;
  assign wb_data        = data_p1;
  assign wb_epoch       = epoch_p1;
  assign wb_grant_id    = gid_p1;
  assign stale_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int N_FU = 4, DEPTH = 2, PHYS_REGS = 64, PHYS_W = 6, DW = 32, EPW = 2, GW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst_n;
  logic [N_FU-1:0]             fu_valid, fu_ready;
  logic [N_FU-1:0][PHYS_W-1:0] fu_pd;
  logic [N_FU-1:0][DW-1:0]     fu_data;
  logic [N_FU-1:0][EPW-1:0]    fu_epoch;
  logic                        flush_valid;
  logic [EPW-1:0]              flush_epoch;
  logic                        wb_valid, wb_ready;
  logic [PHYS_W-1:0]           wb_pd;
  logic [DW-1:0]               wb_data;
  logic [EPW-1:0]              wb_epoch;
  logic [GW-1:0]               wb_grant_id;
  logic [15:0]                 stale_drop_cnt;

  wb_arbiter #(.N_FU(N_FU), .DEPTH(DEPTH), .PHYS_REGS(PHYS_REGS), .DW(DW), .EPW(EPW)) dut (
    .clk(clk), .rst_n(rst_n), .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_pd(fu_pd),
    .fu_data(fu_data), .fu_epoch(fu_epoch), .flush_valid(flush_valid), .flush_epoch(flush_epoch),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pd(wb_pd), .wb_data(wb_data),
    .wb_epoch(wb_epoch), .wb_grant_id(wb_grant_id), .stale_drop_cnt(stale_drop_cnt));

  typedef struct packed {
    logic [PHYS_W-1:0] pd;
    logic [DW-1:0]     data;
    logic [EPW-1:0]    ep;
  } res_t;

  res_t           mq [N_FU][$];
  res_t           m_out;
  logic           m_vld;
  int             m_gid, m_rr, m_drops;
  logic [EPW-1:0] m_ep;
  int             total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Abstract model: advance one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit             acc [N_FU];
    logic [EPW-1:0] eff;
    bit             found;
    int             w;
    if (!rst_n) begin
      for (int i = 0; i < N_FU; i++) mq[i].delete();
      m_vld = 0; m_out = '0; m_gid = 0; m_rr = 0; m_ep = '0; m_drops = 0;
      return;
    end
    for (int i = 0; i < N_FU; i++) acc[i] = fu_valid[i] && (mq[i].size() < DEPTH);
    eff = flush_valid ? flush_epoch : m_ep;
    if (flush_valid) begin
      for (int i = 0; i < N_FU; i++) mq[i].delete();
      m_vld = 0;
      m_ep  = flush_epoch;
    end else if (!m_vld || wb_ready) begin
      found = 0;
      for (int k = 0; k < N_FU; k++) begin
        w = (m_rr + k) % N_FU;
        if (!found && mq[w].size() > 0) begin
          found = 1;
          m_out = mq[w].pop_front();
          m_gid = w;
          m_rr  = (w + 1) % N_FU;
        end
      end
      m_vld = found;
    end
    for (int i = 0; i < N_FU; i++) begin
      if (acc[i]) begin
        if (fu_epoch[i] == eff) mq[i].push_back('{pd: fu_pd[i], data: fu_data[i], ep: fu_epoch[i]});
        else if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic compare();
    logic [N_FU-1:0] exp_rdy;
    for (int i = 0; i < N_FU; i++) exp_rdy[i] = mq[i].size() < DEPTH;
    chk("wb_valid", 64'(wb_valid), 64'(m_vld));
    if (m_vld) begin
      chk("wb_pd", 64'(wb_pd), 64'(m_out.pd));
      chk("wb_data", 64'(wb_data), 64'(m_out.data));
      chk("wb_epoch", 64'(wb_epoch), 64'(m_out.ep));
      chk("wb_grant_id", 64'(wb_grant_id), 64'(m_gid));
    end
    chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    chk("stale_drop_cnt", 64'(stale_drop_cnt), 64'(m_drops));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_pd = '0; fu_data = '0; fu_epoch = '0;
    flush_valid = 1'b0; flush_epoch = '0;
  endtask

  task automatic push(input int i, input int pd, input logic [DW-1:0] data, input int ep);
    fu_valid[i] = 1'b1;
    fu_pd[i]    = PHYS_W'(pd);
    fu_data[i]  = data;
    fu_epoch[i] = EPW'(ep);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int   accepts;
  res_t got_q [$];

  initial begin
    total = 0; bad = 0;
    m_vld = 0; m_out = '0; m_gid = 0; m_rr = 0; m_ep = '0; m_drops = 0;
    idle_inputs();
    wb_ready = 1'b1;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("reset_valid", 64'(wb_valid), 64'd0);
    chk("reset_ready", 64'(fu_ready), 64'hF);
    chk("reset_drops", 64'(stale_drop_cnt), 64'd0);

    // single result from FU2
    push(2, 5, 32'hDEADBEEF, 0);
    step();
    idle_inputs();
    chk("single_lat1", 64'(wb_valid), 64'd0);
    step();
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_pd", 64'(wb_pd), 64'd5);
    chk("single_data", 64'(wb_data), 64'hDEADBEEF);
    chk("single_gid", 64'(wb_grant_id), 64'd2);
    step();
    chk("single_done", 64'(wb_valid), 64'd0);

    // round-robin from a fresh reset, two batches
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N_FU; i++) push(i, 10 + i, 32'(b * 16 + i), 0);
      step();
      idle_inputs();
      for (int k = 0; k < N_FU; k++) begin
        step();
        chk("rr_grant", 64'(wb_grant_id), 64'(k));
        chk("rr_valid", 64'(wb_valid), 64'd1);
      end
      step();
    end

    // backpressure on FU0
    wb_ready = 1'b0;
    accepts  = 0;
    for (int k = 0; k < 5; k++) begin
      push(0, 20 + k, 32'(100 + k), 0);
      if (fu_ready[0]) accepts++;
      step();
    end
    idle_inputs();
    chk("bp_accepts", 64'(accepts), 64'd3);
    chk("bp_ready0", 64'(fu_ready[0]), 64'd0);
    wb_ready = 1'b1;
    got_q.delete();
    for (int k = 0; k < 5; k++) begin
      if (wb_valid) got_q.push_back('{pd: wb_pd, data: wb_data, ep: wb_epoch});
      step();
    end
    chk("bp_count", 64'(got_q.size()), 64'd3);
    for (int k = 0; k < got_q.size() && k < 3; k++) chk("bp_order", 64'(got_q[k].data), 64'(100 + k));

    // flush while FU1 presents a new-epoch result
    wb_ready = 1'b0;
    push(0, 1, 32'h11, 0); push(1, 2, 32'h22, 0); push(2, 3, 32'h33, 0);
    step();
    idle_inputs();
    step();
    flush_valid = 1'b1; flush_epoch = 2'd1; wb_ready = 1'b1;
    push(1, 9, 32'h99, 1);
    step();
    idle_inputs();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    step();
    chk("flush_new_valid", 64'(wb_valid), 64'd1);
    chk("flush_new_pd", 64'(wb_pd), 64'd9);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_no_old", 64'(wb_valid), 64'd0);
    end

    // stale drop at entry
    push(3, 7, 32'h77, 0);
    step();
    idle_inputs();
    chk("stale_cnt", 64'(stale_drop_cnt), 64'd1);
    step();
    chk("stale_no_wb", 64'(wb_valid), 64'd0);

    // reset mid-stream with inputs still active
    wb_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N_FU; i++) push(i, 30 + i, 32'(200 + k * 4 + i), 1);
      step();
    end
    chk("mid_valid_before", 64'(wb_valid), 64'd1);
    flush_valid = 1'b1; flush_epoch = 2'd1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    chk("mid_valid", 64'(wb_valid), 64'd0);
    chk("mid_ready", 64'(fu_ready), 64'hF);
    chk("mid_drops", 64'(stale_drop_cnt), 64'd0);
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_old", 64'(wb_valid), 64'd0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      rst_n    = ($urandom_range(0, 499) != 0);
      wb_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) begin
        flush_valid = 1'b1;
        flush_epoch = EPW'($urandom_range(0, 3));
      end
      for (int i = 0; i < N_FU; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          push(i, int'($urandom_range(0, PHYS_REGS - 1)), $urandom,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3))
                                           : int'(flush_valid ? flush_epoch : m_ep));
        end
      end
      step();
    end
    rst_n = 1'b1;

    // drop counter saturation
    idle_inputs();
    wb_ready = 1'b1;
    do_reset();
    flush_valid = 1'b1; flush_epoch = 2'd1;
    step();
    idle_inputs();
    for (int c = 0; c < 16400; c++) begin
      for (int i = 0; i < N_FU; i++) push(i, i, 32'(c), 0);
      step();
    end
    idle_inputs();
    chk("sat_cnt", 64'(stale_drop_cnt), 64'hFFFF);
    step();
    chk("sat_hold", 64'(stale_drop_cnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter between the functional units and the physical register file's single write port. Each FU pushes results (phys dest, data, epoch) into a private small FIFO. A round-robin arbiter drains the FIFOs into one registered writeback output with a valid/ready handshake. On a mispredict flush, all in-flight results are discarded and results tagged with a stale epoch are dropped at entry.

Parameters:
N_FU, 4, number of functional-unit writeback sources
DEPTH, 2, entries per per-FU FIFO (power of 2, >=2)
PHYS_REGS, 64, physical register count
PHYS_W, $clog2(PHYS_REGS), physical register index width
DW, 32, data width
EPW, 2, epoch tag width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fu_valid  in  [N_FU]x1  FU result valid
fu_ready  out  [N_FU]x1  FIFO can accept
fu_pd  in  [N_FU]xPHYS_W  destination phys reg
fu_data  in  [N_FU]xDW  result data
fu_epoch  in  [N_FU]xEPW  epoch of producing instruction
flush_valid  in  1  mispredict recovery pulse
flush_epoch  in  EPW  new current epoch
wb_valid  out  1  writeback valid (registered)
wb_ready  in  1  PRF accepts writeback
wb_pd  out  PHYS_W  writeback dest
wb_data  out  DW  writeback data
wb_epoch  out  EPW  writeback epoch
wb_grant_id  out  $clog2(N_FU)  source FU of current output
stale_drop_cnt  out  16  saturating count of dropped results

Behaviour:
- Reset (rst_n low at posedge): FIFOs empty; cur_epoch=0; rr_ptr=0; wb_valid=0; wb_pd/wb_data/wb_epoch/wb_grant_id=0; stale_drop_cnt=0. fu_ready reads 1 once reset deasserts (count-based).
- fu_ready[i] = (count[i] < DEPTH), from registered count only. It does not depend on fu_valid or on the same-cycle dequeue.
- Input handshake fu_valid&&fu_ready. The result is enqueued only if fu_epoch == eff_epoch, where eff_epoch = flush_valid ? flush_epoch : cur_epoch. Otherwise the handshake still completes, the result is dropped, and stale_drop_cnt increments by one per dropped result, saturating at 0xFFFF.
- Simultaneous enqueue and dequeue on a full FIFO: still refused, because ready reflects the full state.
- Output register loads when (!wb_valid || wb_ready) and at least one FIFO is non-empty. Winner = first non-empty FIFO scanning rr_ptr, rr_ptr+1, ..., mod N_FU. That FIFO pops in the same cycle; wb_grant_id = winner.
- rr_ptr <= (winner+1) mod N_FU on each load. It is unchanged when nothing loads.
- wb_ready low with wb_valid high: all wb_* outputs held stable, no pop.
- Latency: a result accepted at edge T into an empty system drives wb_valid after edge T+1, i.e. 2 cycles. Sustained throughput is 1 writeback per cycle with wb_ready=1.
- Flush (flush_valid=1 at edge):
  - all FIFO counts go to 0;
  - wb_valid <= 0, and a same-cycle wb_valid&&wb_ready transfer still counts as delivered;
  - cur_epoch <= flush_epoch;
  - no output load occurs that cycle;
  - inputs follow the eff_epoch rule above;
  - rr_ptr is unchanged.
- FIFO pointers wrap mod DEPTH; the count distinguishes full from empty.
- Flushed FIFO contents are not counted in stale_drop_cnt; only entry-time drops are.
- Reset mid-operation discards everything and ignores flush and inputs in that cycle.

Test Plan:
- Single result: FU2 sends pd=5, data=0xDEADBEEF, epoch=0 at edge 0, wb_ready=1 -> wb_valid=1 in cycle 2 with pd=5, data=0xDEADBEEF, wb_grant_id=2; wb_valid=0 in cycle 3.
- Round-robin fairness: all 4 FUs push one result each at the same edge, wb_ready=1 -> grants in order 0,1,2,3 on consecutive cycles. A second simultaneous batch then starts at rr_ptr=0 -> 0,1,2,3 again.
- Backpressure: wb_ready=0 for 5 cycles with FU0 pushing every cycle -> fu_ready[0] drops to 0 after DEPTH+1=3 accepts (2 in FIFO, 1 in output register). wb_* stays stable. Raising wb_ready drains 3 results in order.
- Flush: FIFOs hold 3 results of epoch 0; flush_valid with flush_epoch=1 while FU1 presents epoch=1 pd=9 -> wb_valid=0 next cycle, old results never appear, pd=9 written two cycles later, cur_epoch=1.
- Stale drop: after a flush to epoch 1, FU3 presents epoch=0 -> handshake completes, no writeback, stale_drop_cnt=1. Saturation preset near 0xFFFF holds at 0xFFFF.
- Reset mid-stream: rst_n low for one edge with FIFOs partially full and wb_valid=1 -> wb_valid=0, all fu_ready=1, stale_drop_cnt=0, and no previous data is ever emitted.
